rv16_decode_stage: RTL
======================

# rv16_decode_stage

Registered instruction-decode stage for the rv16 CPU, placed between fetch and register-file read. It accepts raw instruction words over a valid/ready handshake, buffers up to two words in a skid buffer, and presents the split opcode/rs1/rs2/rd fields with registered timing. Each presented instruction also carries an illegal-opcode flag and a read-after-write hazard flag against the previously issued instruction. Field width is parametrised so the same block serves 16-bit and wider instruction words.

## Interface

- DATA, 16, instruction word width; must equal 4*FIELD, otherwise elaboration fails.
- FIELD, 4, width of each of opcode, rs1, rs2 and rd.
- ILLEGAL_MASK, 0, 2**FIELD bits; bit k set marks opcode k illegal.
- NOWB_MASK, 0, 2**FIELD bits; bit k set marks opcode k as not writing rd.
- HAZ_IGNORE_R0, 1, when 1, register address 0 never raises a hazard.

Ports:

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- flush_in  in  1  synchronous flush of buffered instructions and hazard history.
- instr_valid_in  in  1  upstream word valid.
- instr_in  in  DATA  raw instruction word.
- instr_ready_out  out  1  stage can accept a word; driven from a register.
- dec_valid_out  out  1  head entry valid.
- dec_ready_in  in  1  downstream accepts head entry.
- opcode_out  out  FIELD  head instr[FIELD-1:0].
- rs1_addr_out  out  FIELD  head instr[2*FIELD-1:FIELD].
- rs2_addr_out  out  FIELD  head instr[3*FIELD-1:2*FIELD].
- rd_addr_out  out  FIELD  head instr[4*FIELD-1:3*FIELD].
- illegal_out  out  1  ILLEGAL_MASK[opcode_out] for the head entry.
- hazard_out  out  1  RAW hazard on the head entry.
- occupancy_out  out  2  number of buffered entries, 0 to 2.

## Operation

- Storage: 2-entry FIFO (head and tail). Fields and the illegal bit are decoded at push time and stored per entry.
- Push: occurs when instr_valid_in and instr_ready_out are both 1.
- Pop: occurs when dec_valid_out and dec_ready_in are both 1.
- instr_ready_out = (occupancy < 2), registered from the next-state occupancy. Words offered while ready is 0 are not consumed and must be held by upstream.
- dec_valid_out = (occupancy != 0).
- Occupancy 0, push: the word enters head; occupancy becomes 1.
- Occupancy 1, push and pop together: the new word becomes head; occupancy stays 1.
- Occupancy 1, push only: the word enters tail; occupancy becomes 2 and ready drops.
- Occupancy 2, pop: tail moves to head; occupancy becomes 1 and ready rises on the same edge.
- Order is strictly FIFO. No word is dropped or duplicated.
- Hazard history: registers last_rd[FIELD] and last_wb.
  - On each pop: last_rd <= popped rd, and last_wb <= !NOWB_MASK[popped opcode] && !popped illegal.
  - hazard_out = dec_valid_out && last_wb && (rs1_addr_out == last_rd || rs2_addr_out == last_rd) && !(HAZ_IGNORE_R0 && last_rd == 0).
  - hazard_out is advisory. It does not stall the stage.
- Flush: on the next edge, occupancy becomes 0, last_wb becomes 0 and instr_ready_out becomes 1.
  - flush_in has priority over a simultaneous push or pop. A word offered in the flush cycle is discarded, and upstream sees ready=1 but must treat that word as flushed.
- Reset (asynchronous): occupancy 0, all stored fields 0, last_rd 0, last_wb 0, instr_ready_out 1.
  - All outputs are therefore 0 during and after reset, except instr_ready_out, which is 1.
  - Reset mid-transfer discards all buffered entries.

## Timing

- Latency from push to dec_valid_out: 1 cycle.
- Throughput: 1 instruction per cycle when dec_ready_in is held high.
- illegal_out and the field outputs come straight from registers. hazard_out is one comparator level after registers.
- instr_ready_out has no combinational path from dec_ready_in.
- After dec_ready_in falls with a steady input stream, ready deasserts after at most 1 more accepted word, so the buffer holds exactly 2.

## Test plan

- Basic decode: reset, then push 16'h3210 with dec_ready_in=1 -> next cycle opcode 0, rs1 1, rs2 2, rd 3, dec_valid_out=1 and occupancy_out=1; after the pop, occupancy_out=0.
- Backpressure and ordering: dec_ready_in=0, stream 16'hA001, 16'hB002, 16'hC003 -> instr_ready_out=0 after 2 accepted words and C003 is held; release dec_ready_in -> outputs A001, B002, C003 in order with no loss.
- Hazard: with NOWB_MASK=0, pop 16'h5001 (rd=5), then present 16'h7251 (rs1=5) -> hazard_out=1. Repeat with NOWB_MASK bit 1 set -> hazard_out=0. With rd=0 and HAZ_IGNORE_R0=1 -> hazard_out=0.
- Illegal opcode: ILLEGAL_MASK=16'h8000, push 16'h000F -> illegal_out=1. Popping it sets last_wb=0, so the following 16'h0000 shows hazard_out=0.
- Flush: occupancy 2, then flush_in=1 together with a valid push of 16'h1234 -> next cycle occupancy_out=0, dec_valid_out=0, ready=1, and 16'h1234 never appears at the outputs.
- Async reset mid-stream: assert rst between edges while occupancy=2 -> outputs clear immediately without waiting for a clock edge, and instr_ready_out=1.

Source files
------------

// File: rtl/rv16_decode_stage.sv
`timescale 1ns/1ps
// rv16 instruction-decode stage: two-entry skid buffer that splits words into
// opcode/rs1/rs2/rd fields and flags illegal opcodes and RAW hazards.
module rv16_decode_stage #(
  parameter int                  DATA          = 16,
  parameter int                  FIELD         = 4,
  parameter logic [2**FIELD-1:0] ILLEGAL_MASK  = '0,
  parameter logic [2**FIELD-1:0] NOWB_MASK     = '0,
  parameter bit                  HAZ_IGNORE_R0 = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_in,
  input  logic             instr_valid_in,
  input  logic [DATA-1:0]  instr_in,
  output logic             instr_ready_out,
  output logic             dec_valid_out,
  input  logic             dec_ready_in,
  output logic [FIELD-1:0] opcode_out,
  output logic [FIELD-1:0] rs1_addr_out,
  output logic [FIELD-1:0] rs2_addr_out,
  output logic [FIELD-1:0] rd_addr_out,
  output logic             illegal_out,
  output logic             hazard_out,
  output logic [1:0]       occupancy_out
);

  if (DATA != 4 * FIELD) begin : g_bad_width
    $error("rv16_decode_stage: DATA must equal 4*FIELD");
  end

  typedef struct packed {
    logic [FIELD-1:0] rd;
    logic [FIELD-1:0] rs2;
    logic [FIELD-1:0] rs1;
    logic [FIELD-1:0] op;
    logic             ill;
  } entry_t;

  entry_t           r_head, r_tail;
  logic [1:0]       r_occ;
  logic             r_ready;
  logic [FIELD-1:0] r_last_rd;
  logic             r_last_wb;

  entry_t           w_new, w_head_nxt, w_tail_nxt;
  logic [1:0]       w_occ_nxt;
  logic [FIELD-1:0] w_last_rd_nxt;
  logic             w_last_wb_nxt;
  logic             w_push, w_pop;

  assign w_push = instr_valid_in && r_ready;
  assign w_pop  = (r_occ != 2'd0) && dec_ready_in;

  // Decode once at push time so the outputs come straight from registers.
  assign w_new.op  = instr_in[FIELD-1:0];
  assign w_new.rs1 = instr_in[2*FIELD-1:FIELD];
  assign w_new.rs2 = instr_in[3*FIELD-1:2*FIELD];
  assign w_new.rd  = instr_in[4*FIELD-1:3*FIELD];
  assign w_new.ill = ILLEGAL_MASK[instr_in[FIELD-1:0]];

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
    w_occ_nxt     = r_occ;
    w_head_nxt    = r_head;
    w_tail_nxt    = r_tail;
    w_last_rd_nxt = r_last_rd;
    w_last_wb_nxt = r_last_wb;
    if (flush_in) begin
      w_occ_nxt     = 2'd0;
      w_last_wb_nxt = 1'b0;
    end else begin
      if (w_pop) begin
        w_last_rd_nxt = r_head.rd;
        w_last_wb_nxt = !NOWB_MASK[r_head.op] && !r_head.ill;
      end
      case (r_occ)
        2'd0: begin
          if (w_push) begin
            w_head_nxt = w_new;
            w_occ_nxt  = 2'd1;
          end
        end
        2'd1: begin
          if (w_push && w_pop) begin
            w_head_nxt = w_new;
          end else if (w_push) begin
            w_tail_nxt = w_new;
            w_occ_nxt  = 2'd2;
          end else if (w_pop) begin
            w_occ_nxt  = 2'd0;
          end
        end
        2'd2: begin
          // Ready is low here, so only a pop can happen.
          if (w_pop) begin
            w_head_nxt = r_tail;
            w_occ_nxt  = 2'd1;
          end
        end
        default: w_occ_nxt = 2'd0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the entry registers are reset too, so the field outputs read 0 out of reset.
      r_head    <= '0;
      r_tail    <= '0;
      r_occ     <= 2'd0;
      r_ready   <= 1'b1;
      r_last_rd <= '0;
      r_last_wb <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_head    <= w_head_nxt;
      r_tail    <= w_tail_nxt;
      r_occ     <= w_occ_nxt;
      r_ready   <= (w_occ_nxt != 2'd2);
      r_last_rd <= w_last_rd_nxt;
      r_last_wb <= w_last_wb_nxt;
    end
  end

  logic w_addr_hit, w_r0_masked;
  assign w_addr_hit  = (r_head.rs1 == r_last_rd) || (r_head.rs2 == r_last_rd);
  assign w_r0_masked = HAZ_IGNORE_R0 && (r_last_rd == '0);

  assign instr_ready_out = r_ready;
  assign dec_valid_out   = (r_occ != 2'd0);
  assign occupancy_out   = r_occ;
  assign opcode_out      = r_head.op;
  assign rs1_addr_out    = r_head.rs1;
  assign rs2_addr_out    = r_head.rs2;
  assign rd_addr_out     = r_head.rd;
  assign illegal_out     = r_head.ill;
  assign hazard_out      = dec_valid_out && r_last_wb && w_addr_hit && !w_r0_masked;

endmodule
